// File: rtl/ppi_bus_master.sv
// rtl/ppi_bus_master.sv - PPI 8255 CPU-side bus initiator
// Turns single-cycle requests into setup/strobe/hold sequenced read and write cycles.
module ppi_bus_master #(
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 2,
  parameter int HOLD_CYCLES   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  input  logic       we,
  input  logic [1:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       ack,
  inout  wire  [7:0] D,
  output logic [1:0] A,
  output logic       cs,
  output logic       read,
  output logic       write
);

  // A zero-length phase is stretched to one cycle.
  localparam logic [3:0] LP_S = (SETUP_CYCLES  < 1) ? 4'd1 : 4'(SETUP_CYCLES);
  localparam logic [3:0] LP_T = (STROBE_CYCLES < 1) ? 4'd1 : 4'(STROBE_CYCLES);
  localparam logic [3:0] LP_H = (HOLD_CYCLES   < 1) ? 4'd1 : 4'(HOLD_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD
  } state_t;

  state_t     r_state;
  logic [3:0] r_cnt;
  logic       r_we;
  logic [7:0] r_wdata;
  logic [7:0] r_rdata;
  logic [1:0] r_a;
  logic       r_cs;
  logic       r_read;
  logic       r_write;
  logic       r_busy;
  logic       r_ack;
  logic       r_oe;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_wdata <= 8'h00;
      r_rdata <= 8'h00;
      r_a     <= 2'b00;
      r_cs    <= 1'b1;
      r_read  <= 1'b0;
      r_write <= 1'b0;
      r_busy  <= 1'b0;
      r_ack   <= 1'b0;
      r_oe    <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req) begin
            r_we    <= we;
            r_a     <= addr;
            r_wdata <= wdata;
            r_cs    <= 1'b0;
            r_busy  <= 1'b1;
            r_oe    <= we;
            r_cnt   <= LP_S - 4'd1;
            r_state <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (r_cnt == 4'd0) begin
            r_write <= r_we;
            r_read  <= ~r_we;
            r_cnt   <= LP_T - 4'd1;
            r_state <= ST_STROBE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_STROBE: begin
          if (r_cnt == 4'd0) begin
            r_write <= 1'b0;
            r_read  <= 1'b0;
            if (!r_we) r_rdata <= D;
            r_cnt   <= LP_H - 4'd1;
            r_state <= ST_HOLD;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_HOLD: begin
          // A stays at the last address; only cs and the data driver release.
          if (r_cnt == 4'd0) begin
            r_cs    <= 1'b1;
            r_oe    <= 1'b0;
            r_busy  <= 1'b0;
            r_ack   <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign D     = r_oe ? r_wdata : 8'hzz;
  assign rdata = r_rdata;
  assign busy  = r_busy;
  assign ack   = r_ack;
  assign A     = r_a;
  assign cs    = r_cs;
  assign read  = r_read;
  assign write = r_write;

endmodule

// File: tb/tb_ppi_bus_master.sv
// tb/tb_ppi_bus_master.sv - randomized bench for ppi_bus_master against a timeline model
// Two instances: default timing and a 2/3/2 setup/strobe/hold sweep.
module tb_ppi_bus_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       req_s  [2];
  logic       we_s   [2];
  logic [1:0] addr_s [2];
  logic [7:0] wd_s   [2];
  logic       tb_en  [2];
  logic [7:0] tb_val [2];

  wire  [7:0] d0, d1;
  assign d0 = tb_en[0] ? tb_val[0] : 8'hzz;
  assign d1 = tb_en[1] ? tb_val[1] : 8'hzz;

  logic [7:0] rdata0, rdata1;
  logic [1:0] a0, a1;
  logic       busy0, busy1, ack0, ack1, cs0, cs1, rd0, rd1, wr0, wr1;

  ppi_bus_master u_dut0 (
    .clk(clk), .reset(reset), .req(req_s[0]), .we(we_s[0]), .addr(addr_s[0]),
    .wdata(wd_s[0]), .rdata(rdata0), .busy(busy0), .ack(ack0), .D(d0), .A(a0),
    .cs(cs0), .read(rd0), .write(wr0)
  );

  ppi_bus_master #(.SETUP_CYCLES(2), .STROBE_CYCLES(3), .HOLD_CYCLES(2)) u_dut1 (
    .clk(clk), .reset(reset), .req(req_s[1]), .we(we_s[1]), .addr(addr_s[1]),
    .wdata(wd_s[1]), .rdata(rdata1), .busy(busy1), .ack(ack1), .D(d1), .A(a1),
    .cs(cs1), .read(rd1), .write(wr1)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int p_s(input int i); return (i == 1) ? 2 : 1; endfunction
  function automatic int p_t(input int i); return (i == 1) ? 3 : 2; endfunction
  function automatic int p_h(input int i); return (i == 1) ? 2 : 1; endfunction

  // Model: each access is a timeline relative to its acceptance edge E.
  int         cyc = 0;
  bit         m_act  [2];
  int         m_e    [2];
  bit         m_we   [2];
  logic [1:0] m_addr [2];
  logic [7:0] m_wd   [2];
  logic [7:0] m_rd   [2];
  bit         e_cs [2], e_busy [2], e_rd [2], e_wr [2], e_ack [2], e_dr [2];

  task automatic m_reset();
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 0; m_e[i] = 0; m_we[i] = 0; m_addr[i] = 2'b00;
      m_wd[i] = 8'h00; m_rd[i] = 8'h00;
      e_cs[i] = 1; e_busy[i] = 0; e_rd[i] = 0; e_wr[i] = 0; e_ack[i] = 0; e_dr[i] = 0;
      tb_en[i] = 1'b1;
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      m_reset();
    end else begin
      for (int i = 0; i < 2; i++) begin
        int s, t, l, k;
        s = p_s(i); t = p_t(i); l = s + t + p_h(i);
        if (m_act[i] && !m_we[i] && cyc == m_e[i] + s + t) m_rd[i] = tb_val[i];
        if ((!m_act[i] || cyc >= m_e[i] + l + 1) && req_s[i]) begin
          m_act[i] = 1; m_e[i] = cyc; m_we[i] = we_s[i];
          m_addr[i] = addr_s[i]; m_wd[i] = wd_s[i];
        end
        k = cyc - m_e[i];
        e_busy[i] = m_act[i] && k < l;
        e_cs[i]   = !e_busy[i];
        e_wr[i]   = m_act[i] && m_we[i] && k >= s && k < s + t;
        e_rd[i]   = m_act[i] && !m_we[i] && k >= s && k < s + t;
        e_ack[i]  = m_act[i] && k == l;
        e_dr[i]   = e_busy[i] && m_we[i];
        tb_en[i]  = !e_dr[i];
      end
    end
  end

  task automatic check_dut(input int i, input logic o_cs, input logic o_busy, input logic o_rd,
                           input logic o_wr, input logic o_ack, input logic [1:0] o_a,
                           input logic [7:0] o_rdata, input logic [7:0] o_d);
    check($sformatf("d%0d.cs", i), {31'd0, o_cs}, {31'd0, e_cs[i]});
    check($sformatf("d%0d.busy", i), {31'd0, o_busy}, {31'd0, e_busy[i]});
    check($sformatf("d%0d.read", i), {31'd0, o_rd}, {31'd0, e_rd[i]});
    check($sformatf("d%0d.write", i), {31'd0, o_wr}, {31'd0, e_wr[i]});
    check($sformatf("d%0d.ack", i), {31'd0, o_ack}, {31'd0, e_ack[i]});
    check($sformatf("d%0d.A", i), {30'd0, o_a}, {30'd0, m_addr[i]});
    check($sformatf("d%0d.rdata", i), {24'd0, o_rdata}, {24'd0, m_rd[i]});
    check($sformatf("d%0d.D", i), {24'd0, o_d}, {24'd0, e_dr[i] ? m_wd[i] : tb_val[i]});
  endtask

  task automatic check_all();
    check_dut(0, cs0, busy0, rd0, wr0, ack0, a0, rdata0, d0);
    check_dut(1, cs1, busy1, rd1, wr1, ack1, a1, rdata1, d1);
  endtask

  initial begin
    int n_resets;
    bit rst_pending;
    n_resets = 0;
    rst_pending = 0;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req_s[i] = 0; we_s[i] = 0; addr_s[i] = 2'b00; wd_s[i] = 8'h00; tb_val[i] = 8'h00;
    end
    m_reset();
    repeat (3) @(negedge clk);
    check_all();
    reset = 1'b0;

    for (int n = 0; n < 800; n++) begin
      @(negedge clk);
      check_all();
      if (rst_pending) begin
        reset = 1'b0;
        rst_pending = 0;
      end
      if (n == 0) begin
        req_s[0] = 1; we_s[0] = 1; addr_s[0] = 2'b11; wd_s[0] = 8'h80;
        req_s[1] = 1; we_s[1] = 0; addr_s[1] = 2'b10; wd_s[1] = 8'h00; tb_val[1] = 8'hFF;
        tb_val[0] = 8'h00;
      end else begin
        for (int i = 0; i < 2; i++) begin
          req_s[i]  = ($urandom_range(0, 9) < 6);
          we_s[i]   = $urandom_range(0, 1) == 1;
          addr_s[i] = 2'($urandom_range(0, 3));
          wd_s[i]   = 8'($urandom_range(0, 255));
          if (n > 12) tb_val[i] = 8'($urandom_range(0, 255));
        end
      end
      // Abort a write mid-strobe a few times and check the async clear.
      if (n > 20 && n_resets < 4 && e_wr[0] && $urandom_range(0, 2) == 0) begin
        #1;
        reset = 1'b1;
        m_reset();
        #1;
        check_all();
        n_resets++;
        rst_pending = 1;
      end
    end
    check("reset_events", (n_resets > 0) ? 32'd1 : 32'd0, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ppi_bus_master.md
# ppi_bus_master

Synchronous bus initiator that drives the CPU-side interface of the PPI_8255 block: D, A, cs, read, write. It converts single-cycle requests from an internal controller into properly sequenced 8255 read and write cycles. Each cycle has parameterised setup, strobe and hold phases. Read data is captured from D and returned with a one-cycle acknowledge. It sits between a sequencer or CPU model and the PPI_8255, replacing hand-written bus stimulus.

## Interface
- SETUP_CYCLES, 1, cycles with cs/A/D valid before strobe (legal 1..15; 0 behaves as 1)
- STROBE_CYCLES, 2, cycles read or write is held high (legal 1..15; 0 behaves as 1)
- HOLD_CYCLES, 1, cycles cs/A/D held after strobe falls (legal 1..15; 0 behaves as 1)

Ports:
- clk  in  1  single clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high; forces reset values immediately
- req  in  1  request strobe; sampled only when busy=0
- we  in  1  1 = write cycle, 0 = read cycle (sampled with req)
- addr  in  2  PPI register select: 00 A, 01 B, 10 C, 11 control (sampled with req)
- wdata  in  8  write data (sampled with req)
- rdata  out  8  read data, valid while ack=1 and held until next read completes
- busy  out  1  high while a bus cycle is in progress
- ack  out  1  one-cycle pulse on completion of any cycle
- D  inout  8  PPI data bus; driven only during write cycles, otherwise high-Z
- A  out  2  PPI address, drives PPI_8255 A_in
- cs  out  1  chip select, active-low
- read  out  1  read strobe, active-high
- write  out  1  write strobe, active-high

## Operation
- FSM states: IDLE, SETUP, STROBE, HOLD. A 4-bit phase counter counts down within each non-IDLE state.
- Reset values: state IDLE; cs=1; read=0; write=0; A=00; D=Z; busy=0; ack=0; rdata=00.
- IDLE: if req=1, latch we/addr/wdata and go to SETUP on that edge; otherwise remain in IDLE. Requests arriving while busy=1 are ignored, not queued.
- SETUP: cs=0, A=latched addr, D=wdata if we else Z; read=write=0. Lasts SETUP_CYCLES cycles.
- STROBE: as SETUP, plus write=1 (we=1) or read=1 (we=0); the two strobes are never high together. Lasts STROBE_CYCLES cycles.
- On a read cycle, rdata captures D on the clock edge that ends STROBE.
- HOLD: strobes 0; cs, A and D unchanged from STROBE. Lasts HOLD_CYCLES cycles.
- The edge ending HOLD returns the FSM to IDLE: cs=1, D=Z, A keeps its last value, busy=0, ack=1 for exactly one cycle.
- busy=1 in SETUP, STROBE and HOLD; busy=0 in IDLE.
- Asynchronous reset in any state aborts the cycle at once: outputs go to reset values, no ack is issued, and rdata is cleared.

## Timing
- Acceptance edge E: req=1 while in IDLE. cs falls and busy rises right after E.
- Strobe high from E+SETUP_CYCLES to E+SETUP_CYCLES+STROBE_CYCLES.
- ack high in the cycle after edge E+S+T+H, where S=SETUP_CYCLES, T=STROBE_CYCLES, H=HOLD_CYCLES. With defaults, ack follows E+4.
- Back-to-back operation:
  - A req held high during the ack cycle is accepted on the next edge.
  - cs is therefore high for exactly one cycle between consecutive accesses.
  - Sustained throughput is one access per S+T+H+1 cycles.
- D direction changes only at IDLE↔SETUP boundaries, never while a strobe is high.

## Test plan
- Control write, defaults: req, we=1, addr=11, wdata=0x80 at edge E → cs=0 from E; write=1 exactly from E+1 to E+3; D=0x80 from E to E+4; ack pulse after E+4; read never high; D=Z afterwards.
- Port A read: bench drives D=0xF0 while read=1, addr=00 → cs=0 and A=00 throughout; rdata=0xF0 with ack; D never driven by the block.
- Back-to-back: writes to addr 00 then 01 with req held high → second acceptance in the ack cycle; cs high exactly one cycle between accesses; two ack pulses 5 cycles apart.
- Busy rejection: pulse req (write 0x55 to addr 10) during STROBE of a read → no extra bus cycle and only one ack.
- Reset mid-strobe: assert reset while write=1 → cs=1, write=0, D=Z, busy=0 asynchronously; no ack; the next request after reset release completes normally.
- Parameter sweep: SETUP=2, STROBE=3, HOLD=2, read addr 10 with D=0xFF → read high for exactly 3 cycles starting 2 cycles after acceptance; ack 7 cycles after acceptance; rdata=0xFF.
